// File: rtl/sm_cpu_pkg.sv
// Shared opcode/funct encodings and ALU operation type for the sm_cpu core.
// The IN opcode is only decoded when SM_CPU_EXTIN_EN is defined.
package sm_cpu_pkg;

   localparam logic [5:0] C_SPEC  = 6'b000000;
   localparam logic [5:0] C_ADDIU = 6'b001001;
   localparam logic [5:0] C_LUI   = 6'b001111;
   localparam logic [5:0] C_BEQ   = 6'b000100;
   localparam logic [5:0] C_BNE   = 6'b000101;
   localparam logic [5:0] C_IN    = 6'b011111;

   localparam logic [5:0] F_ADDU  = 6'b100001;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_SRL   = 6'b000010;
   localparam logic [5:0] F_SLTU  = 6'b101011;
   localparam logic [5:0] F_SUBU  = 6'b100011;
   // Don't-care funct value for instructions whose funct field carries no meaning
   localparam logic [5:0] F_ANY   = 6'b000000;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_OR,
      ALU_SRL,
      ALU_SLTU,
      ALU_SUB,
      ALU_LUI,
      ALU_IN
   } alu_op_e;

endpackage

// File: rtl/sm_register_file.sv
// 32x32 register file: two datapath read ports, one debug read port, one write port.
// Register 0 is hard-wired to zero on every read port and never written.
module sm_register_file
   import sm_cpu_pkg::*;
(
   input  logic        clk,
   input  logic [4:0]  a1,
   input  logic [4:0]  a2,
   input  logic [4:0]  a3,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   output logic [31:0] rd3,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   input  logic        we
);

   logic [31:0] rf_q [0:31];

   // Storage is intentionally not reset; software initialises what it uses
   always_ff @(posedge clk) begin
      if (we && (wa != 5'd0)) begin
         rf_q[wa] <= wd;
      end
   end

   always_comb begin
      rd1 = (a1 == 5'd0) ? 32'h0 : rf_q[a1];
      rd2 = (a2 == 5'd0) ? 32'h0 : rf_q[a2];
      rd3 = (a3 == 5'd0) ? 32'h0 : rf_q[a3];
   end

endmodule

// File: rtl/sm_cpu_core.sv
// Single-cycle MIPS-subset core: fetch, decode, execute and write-back in one clock.
// Define SM_CPU_EXTIN_EN to enable the IN instruction reading extData.
module sm_cpu_core
   import sm_cpu_pkg::*;
#(
   parameter logic [31:0] PC_RESET = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  regAddr,
   output logic [31:0] regData,
   output logic [31:0] imAddr,
   input  logic [31:0] imData,
   input  logic [7:0]  extData
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_plus1, pc_branch;

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, sa;
   logic [15:0] imm;
   logic [31:0] imm_sext;

   logic [31:0] rs_data, rt_data, dbg_data;
   logic [31:0] alu_b, alu_result;
   alu_op_e     alu_op;
   logic        use_imm;
   logic        rf_we;
   logic [4:0]  rf_wa;

   assign op       = imData[31:26];
   assign rs       = imData[25:21];
   assign rt       = imData[20:16];
   assign rd       = imData[15:11];
   assign sa       = imData[10:6];
   assign funct    = imData[5:0];
   assign imm      = imData[15:0];
   assign imm_sext = {{16{imm[15]}}, imm};

   assign pc_plus1  = pc_q + 32'd1;
   assign pc_branch = pc_plus1 + imm_sext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= PC_RESET;
      end else begin
         pc_q <= pc_d;
      end
   end

   always_comb begin
      alu_op  = ALU_ADD;
      use_imm = 1'b0;
      rf_we   = 1'b0;
      rf_wa   = rd;
      pc_d    = pc_plus1;
      case (op)
         C_SPEC: begin
            rf_we = 1'b1;
            case (funct)
               F_ADDU:  alu_op = ALU_ADD;
               F_OR:    alu_op = ALU_OR;
               F_SRL:   alu_op = ALU_SRL;
               F_SLTU:  alu_op = ALU_SLTU;
               F_SUBU:  alu_op = ALU_SUB;
               default: rf_we  = 1'b0;
            endcase
         end
         C_ADDIU: begin
            alu_op  = ALU_ADD;
            use_imm = 1'b1;
            rf_we   = 1'b1;
            rf_wa   = rt;
         end
         C_LUI: begin
            alu_op = ALU_LUI;
            rf_we  = 1'b1;
            rf_wa  = rt;
         end
         C_BEQ: if (rs_data == rt_data) pc_d = pc_branch;
         C_BNE: if (rs_data != rt_data) pc_d = pc_branch;
`ifdef SM_CPU_EXTIN_EN
         C_IN: begin
            alu_op = ALU_IN;
            rf_we  = 1'b1;
            rf_wa  = rt;
         end
`endif
         default: ;
      endcase
   end

   assign alu_b = use_imm ? imm_sext : rt_data;

   always_comb begin
      alu_result = 32'h0;
      case (alu_op)
         ALU_ADD:  alu_result = rs_data + alu_b;
         ALU_OR:   alu_result = rs_data | alu_b;
         ALU_SRL:  alu_result = alu_b >> sa;
         ALU_SLTU: alu_result = (rs_data < alu_b) ? 32'd1 : 32'd0;
         ALU_SUB:  alu_result = rs_data - alu_b;
         ALU_LUI:  alu_result = {imm, 16'h0};
`ifdef SM_CPU_EXTIN_EN
         ALU_IN:   alu_result = {24'h0, extData};
`endif
         default:  alu_result = 32'h0;
      endcase
   end

`ifndef SM_CPU_EXTIN_EN
   logic unused_extdata;
   assign unused_extdata = ^extData;
`endif

   // Writes are suppressed while reset is held so the register file survives a mid-program reset
   sm_register_file u_rf (
      .clk (clk),
      .a1  (rs),
      .a2  (rt),
      .a3  (regAddr),
      .rd1 (rs_data),
      .rd2 (rt_data),
      .rd3 (dbg_data),
      .wa  (rf_wa),
      .wd  (alu_result),
      .we  (rf_we & ~rst)
   );

   assign imAddr  = pc_q;
   assign regData = (regAddr == 5'd0) ? pc_q : dbg_data;

endmodule

// File: tb/tb_sm_cpu_core.sv
// Directed-vector bench for sm_cpu_core with a behavioural combinational ROM.
module tb_sm_cpu_core;

   logic        clk;
   logic        rst;
   logic [4:0]  regAddr;
   logic [31:0] regData;
   logic [31:0] imAddr;
   logic [31:0] imData;
   logic [7:0]  extData;

   logic [31:0] rom [0:63];
   int total;
   int bad;

   sm_cpu_core #(.PC_RESET(32'h0)) dut (
      .clk     (clk),
      .rst     (rst),
      .regAddr (regAddr),
      .regData (regData),
      .imAddr  (imAddr),
      .imData  (imData),
      .extData (extData)
   );

   assign imData = (imAddr < 32'd64) ? rom[imAddr[5:0]] : 32'h0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sa,
                                         input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, sa, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 64; i++) rom[i] = 32'h0;
   endtask

   task automatic restart();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic rd_reg(input logic [4:0] a, output logic [31:0] v);
      regAddr = a;
      #1;
      v = regData;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      clear_rom();
      rst = 1'b1;
      regAddr = 5'd0;
      repeat (4) step();
      total++;
      if (imAddr !== 32'h0) begin
         bad++; $display("FAIL reset_imaddr got=%h exp=%h", imAddr, 32'h0);
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rd_reg(5'd0, v);
         total++;
         if (v !== i) begin
            bad++; $display("FAIL reset_pc_step%0d got=%h exp=%h", i, v, i);
         end
         step();
      end
   endtask

   task automatic test_arith();
      logic [31:0] v;
      logic [31:0] exp_v [2:6];
      clear_rom();
      rom[0] = enc_i(6'b001001, 5'd0, 5'd2, 16'd5);
      rom[1] = enc_i(6'b001001, 5'd0, 5'd3, 16'hFFFF);
      rom[2] = enc_r(5'd2, 5'd3, 5'd4, 5'd0, 6'b100001);
      rom[3] = enc_r(5'd2, 5'd3, 5'd5, 5'd0, 6'b101011);
      rom[4] = enc_r(5'd2, 5'd3, 5'd6, 5'd0, 6'b100011);
      restart();
      repeat (5) step();
      exp_v[2] = 32'd5; exp_v[3] = 32'hFFFFFFFF; exp_v[4] = 32'd4;
      exp_v[5] = 32'd1; exp_v[6] = 32'd6;
      for (int r = 2; r <= 6; r++) begin
         rd_reg(r[4:0], v);
         total++;
         if (v !== exp_v[r]) begin
            bad++; $display("FAIL arith_r%0d got=%h exp=%h", r, v, exp_v[r]);
         end
      end
   endtask

   task automatic test_logic();
      logic [31:0] v;
      clear_rom();
      rom[0] = enc_i(6'b001001, 5'd0, 5'd3, 16'h5678);
      rom[1] = enc_i(6'b001111, 5'd0, 5'd2, 16'h1234);
      rom[2] = enc_r(5'd2, 5'd3, 5'd2, 5'd0, 6'b100101);
      rom[3] = enc_r(5'd0, 5'd2, 5'd7, 5'd4, 6'b000010);
      restart();
      repeat (4) step();
      rd_reg(5'd2, v);
      total++;
      if (v !== 32'h12345678) begin
         bad++; $display("FAIL lui_or got=%h exp=%h", v, 32'h12345678);
      end
      rd_reg(5'd7, v);
      total++;
      if (v !== 32'h01234567) begin
         bad++; $display("FAIL srl got=%h exp=%h", v, 32'h01234567);
      end
   endtask

   task automatic test_branch();
      logic [31:0] v;
      logic [31:0] exp_pc [0:7];
      exp_pc = '{32'd0, 32'd1, 32'd2, 32'd1, 32'd2, 32'd1, 32'd2, 32'd3};
      clear_rom();
      rom[0] = enc_i(6'b001001, 5'd0, 5'd2, 16'd3);
      rom[1] = enc_i(6'b001001, 5'd2, 5'd2, 16'hFFFF);
      rom[2] = enc_i(6'b000101, 5'd2, 5'd0, 16'hFFFE);
      rom[3] = enc_i(6'b000100, 5'd0, 5'd0, 16'hFFFF);
      restart();
      for (int i = 0; i < 8; i++) begin
         total++;
         if (imAddr !== exp_pc[i]) begin
            bad++; $display("FAIL loop_pc%0d got=%h exp=%h", i, imAddr, exp_pc[i]);
         end
         step();
      end
      rd_reg(5'd2, v);
      total++;
      if (v !== 32'd0) begin
         bad++; $display("FAIL loop_exit_r2 got=%h exp=%h", v, 32'd0);
      end
      repeat (3) step();
      total++;
      if (imAddr !== 32'd3) begin
         bad++; $display("FAIL beq_selfloop got=%h exp=%h", imAddr, 32'd3);
      end
   endtask

   task automatic test_zero_reg();
      logic [31:0] v;
      clear_rom();
      rom[0] = enc_i(6'b001001, 5'd0, 5'd9, 16'd9);
      rom[1] = enc_i(6'b001001, 5'd0, 5'd0, 16'd7);
      rom[2] = enc_r(5'd0, 5'd0, 5'd9, 5'd0, 6'b100001);
      rom[3] = 32'h0;
      rom[4] = 32'hFFFFFFFF;
      restart();
      repeat (5) step();
      rd_reg(5'd0, v);
      total++;
      if (v !== 32'd5) begin
         bad++; $display("FAIL dbg_r0_is_pc got=%h exp=%h", v, 32'd5);
      end
      rd_reg(5'd9, v);
      total++;
      if (v !== 32'd0) begin
         bad++; $display("FAIL r0_operand got=%h exp=%h", v, 32'd0);
      end
   endtask

   task automatic test_extin();
      logic [31:0] v;
      logic [31:0] exp_r2;
`ifdef SM_CPU_EXTIN_EN
      exp_r2 = 32'd4;
`else
      exp_r2 = 32'h11;
`endif
      clear_rom();
      rom[0] = enc_i(6'b001001, 5'd0, 5'd2, 16'h0011);
      rom[1] = enc_i(6'b011111, 5'd0, 5'd2, 16'h0000);
      extData = 8'd4;
      restart();
      repeat (2) step();
      total++;
      if (imAddr !== 32'd2) begin
         bad++; $display("FAIL in_pc got=%h exp=%h", imAddr, 32'd2);
      end
      rd_reg(5'd2, v);
      total++;
      if (v !== exp_r2) begin
         bad++; $display("FAIL in_r2 got=%h exp=%h", v, exp_r2);
      end
   endtask

   task automatic test_mid_reset();
      logic [31:0] v;
      clear_rom();
      rom[0] = enc_i(6'b001001, 5'd0, 5'd12, 16'h0077);
      rom[1] = enc_i(6'b001001, 5'd12, 5'd12, 16'd1);
      restart();
      repeat (2) step();
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (imAddr !== 32'd0) begin
         bad++; $display("FAIL midrst_imaddr got=%h exp=%h", imAddr, 32'd0);
      end
      repeat (2) step();
      rd_reg(5'd12, v);
      total++;
      if (v !== 32'h78) begin
         bad++; $display("FAIL midrst_retain got=%h exp=%h", v, 32'h78);
      end
      rst = 1'b0;
      step();
      rd_reg(5'd12, v);
      total++;
      if (v !== 32'h77) begin
         bad++; $display("FAIL midrst_rerun got=%h exp=%h", v, 32'h77);
      end
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      rst     = 1'b1;
      regAddr = 5'd0;
      extData = 8'd0;
      test_reset();
      test_arith();
      test_logic();
      test_branch();
      test_zero_reg();
      test_extin();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
